// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between the MEM pipeline stage and the data memory controller.
// The requester uses the master modport; the controller uses the slave modport.
interface data_memory_ctrl_if #(
    parameter int DATA_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [DATA_W/8-1:0]   req_be;
    logic [31:0]           req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_memory_ctrl.sv
// Word-organised synchronous data RAM behind a single-outstanding valid/ready handshake.
// Define DMEM_MISALIGN_TRAP_EN to report non-word-aligned addresses as errors.
module data_memory_ctrl #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 65536,
    parameter int READ_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    data_memory_ctrl_if.slave  bus
);
    localparam int BE_W      = DATA_W / 8;
    localparam int OFF_W     = $clog2(BE_W);
    localparam int IDX_W     = $clog2(DEPTH);
    localparam int ADDR_USED = OFF_W + IDX_W;
    localparam logic [31:0] OFF_MASK = (32'd1 << OFF_W) - 32'd1;
    localparam logic [3:0]  LAT      = 4'(READ_LAT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ram_q;
    logic              rd_ok_q;
    logic              err_q;

    logic [IDX_W-1:0]  idx;
    logic              out_of_range;
    logic              misaligned;
    logic              bad_addr;
    logic              accept;

    assign idx          = bus.req_addr[OFF_W +: IDX_W];
    assign out_of_range = (bus.req_addr >> ADDR_USED) != 32'd0;
`ifdef DMEM_MISALIGN_TRAP_EN
    assign misaligned   = (bus.req_addr & OFF_MASK) != 32'd0;
`else
    assign misaligned   = 1'b0;
`endif
    assign bad_addr     = out_of_range || misaligned;
    assign accept       = bus.req_valid && (state == ST_IDLE) && !rst;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // NOTE: every variable gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    cnt_nxt   = 4'd1;
                    state_nxt = (LAT == 4'd1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_nxt = cnt + 4'd1;
                if (cnt + 4'd1 == LAT) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: the RAM array and its read register are deliberately not reset so
    // the storage maps onto block RAM; the reset-clean rd_ok_q masks the output.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (bus.req_we && !bad_addr) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (bus.req_be[i]) mem[idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
                end
            end
            ram_q <= mem[idx];
        end
    end

    // Response qualifiers captured at accept; held untouched while the response waits.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ok_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (accept) begin
            rd_ok_q <= !bus.req_we && !bad_addr;
            err_q   <= bad_addr;
        end
    end

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.rsp_valid = (state == ST_RESP);
    assign bus.rsp_rdata = rd_ok_q ? ram_q : '0;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: one instance at READ_LAT=1, one at READ_LAT=3.
// Expectations for misaligned writes follow DMEM_MISALIGN_TRAP_EN.
module tb_data_memory_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    data_memory_ctrl_if #(.DATA_W(32)) bus1 ();
    data_memory_ctrl_if #(.DATA_W(32)) bus3 ();

    data_memory_ctrl #(.DATA_W(32), .DEPTH(65536), .READ_LAT(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    data_memory_ctrl #(.DATA_W(32), .DEPTH(65536), .READ_LAT(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete access on the READ_LAT=1 instance; lat counts edges from accept to rsp_valid.
    task automatic access1(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] be, output logic [31:0] rd, output logic err,
                           output int lat);
        bus1.req_valid = 1'b1;
        bus1.req_we    = we;
        bus1.req_addr  = addr;
        bus1.req_wdata = wd;
        bus1.req_be    = be;
        bus1.rsp_ready = 1'b1;
        step();
        bus1.req_valid = 1'b0;
        lat = 1;
        while (!bus1.rsp_valid && lat < 20) begin
            step();
            lat++;
        end
        rd  = bus1.rsp_rdata;
        err = bus1.rsp_err;
        step();
    endtask

    // Drives one request into the READ_LAT=3 instance and releases req_valid after the accept edge.
    task automatic issue3(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        bus3.req_valid = 1'b1;
        bus3.req_we    = we;
        bus3.req_addr  = addr;
        bus3.req_wdata = wd;
        bus3.req_be    = 4'hF;
        bus3.rsp_ready = 1'b1;
        step();
        bus3.req_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        int          lat;

        rst = 1'b1;
        bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_be = '0;
        bus1.req_addr  = '0;   bus1.req_wdata = '0; bus1.rsp_ready = 1'b0;
        bus3.req_valid = 1'b0; bus3.req_we = 1'b0; bus3.req_be = '0;
        bus3.req_addr  = '0;   bus3.req_wdata = '0; bus3.rsp_ready = 1'b0;
        step();
        step();
        check("rst_req_ready", bus1.req_ready, 1);
        check("rst_rsp_valid", bus1.rsp_valid, 0);
        check("rst_rsp_rdata", bus1.rsp_rdata, 0);
        check("rst_rsp_err",   bus1.rsp_err,   0);
        check("rst3_req_ready", bus3.req_ready, 1);
        check("rst3_rsp_valid", bus3.rsp_valid, 0);
        rst = 1'b0;
        step();

        // Full-word write then read back at latency 1
        access1(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, err, lat);
        check("t1_wr_lat",   lat, 1);
        check("t1_wr_err",   err, 0);
        check("t1_wr_rdata", rd,  0);
        check("t1_idle_rsp_valid", bus1.rsp_valid, 0);
        check("t1_idle_req_ready", bus1.req_ready, 1);
        access1(1'b0, 32'h10, 32'h0, 4'h0, rd, err, lat);
        check("t1_rd_lat",   lat, 1);
        check("t1_rd_err",   err, 0);
        check("t1_rd_rdata", rd,  32'hDEADBEEF);

        // Byte-enabled merge, then an all-zero-enable write that must change nothing
        access1(1'b1, 32'h20, 32'h11223344, 4'hF, rd, err, lat);
        access1(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, err, lat);
        access1(1'b0, 32'h20, 32'h0, 4'h0, rd, err, lat);
        check("t2_merge", rd, 32'h11BB33DD);
        access1(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, rd, err, lat);
        check("t2_be0_ack_err", err, 0);
        access1(1'b0, 32'h20, 32'h0, 4'h0, rd, err, lat);
        check("t2_be0_unchanged", rd, 32'h11BB33DD);

        // Backpressure: response held stable, a queued write must wait for the handshake
        bus1.req_valid = 1'b1; bus1.req_we = 1'b0; bus1.req_addr = 32'h10;
        bus1.rsp_ready = 1'b0;
        step();
        bus1.req_we = 1'b1; bus1.req_wdata = 32'h0; bus1.req_be = 4'hF;
        for (int i = 0; i < 4; i++) begin
            check("t4_hold_valid",     bus1.rsp_valid, 1);
            check("t4_hold_rdata",     bus1.rsp_rdata, 32'hDEADBEEF);
            check("t4_hold_req_ready", bus1.req_ready, 0);
            step();
        end
        bus1.rsp_ready = 1'b1;
        check("t4_release_rdata", bus1.rsp_rdata, 32'hDEADBEEF);
        step();
        check("t4_after_hs_valid", bus1.rsp_valid, 0);
        check("t4_after_hs_ready", bus1.req_ready, 1);
        step();
        bus1.req_valid = 1'b0;
        check("t4_queued_ack_valid", bus1.rsp_valid, 1);
        check("t4_queued_ack_rdata", bus1.rsp_rdata, 0);
        step();
        access1(1'b0, 32'h10, 32'h0, 4'h0, rd, err, lat);
        check("t4_queued_wr_done", rd, 32'h0);

        // Out of range: error response, no aliasing onto word 0
        access1(1'b1, 32'h0, 32'h12345678, 4'hF, rd, err, lat);
        access1(1'b0, 32'h0004_0000, 32'h0, 4'h0, rd, err, lat);
        check("t5_rd_err",   err, 1);
        check("t5_rd_rdata", rd,  0);
        access1(1'b1, 32'h0004_0000, 32'hFFFFFFFF, 4'hF, rd, err, lat);
        check("t5_wr_err", err, 1);
        check("t5_wr_lat", lat, 1);
        access1(1'b0, 32'h0, 32'h0, 4'h0, rd, err, lat);
        check("t5_alias", rd, 32'h12345678);

        // Misaligned write
        access1(1'b1, 32'h10, 32'h55667788, 4'hF, rd, err, lat);
        access1(1'b1, 32'h13, 32'hCAFEBABE, 4'hF, rd, err, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("t6_mis_err", err, 1);
        access1(1'b0, 32'h10, 32'h0, 4'h0, rd, err, lat);
        check("t6_mis_word", rd, 32'h55667788);
`else
        check("t6_mis_err", err, 0);
        access1(1'b0, 32'h10, 32'h0, 4'h0, rd, err, lat);
        check("t6_mis_word", rd, 32'hCAFEBABE);
`endif

        // Latency 3: write then read with per-edge timing
        issue3(1'b1, 32'h8, 32'h01020304);
        check("t3_wr_busy0", bus3.req_ready, 0);
        step();
        step();
        check("t3_wr_valid", bus3.rsp_valid, 1);
        step();
        issue3(1'b0, 32'h8, 32'h0);
        check("t3_rd_e1_ready", bus3.req_ready, 0);
        check("t3_rd_e1_valid", bus3.rsp_valid, 0);
        step();
        check("t3_rd_e2_ready", bus3.req_ready, 0);
        check("t3_rd_e2_valid", bus3.rsp_valid, 0);
        step();
        check("t3_rd_e3_ready", bus3.req_ready, 0);
        check("t3_rd_e3_valid", bus3.rsp_valid, 1);
        check("t3_rd_rdata",    bus3.rsp_rdata, 32'h01020304);
        step();
        check("t3_done_valid", bus3.rsp_valid, 0);
        check("t3_done_ready", bus3.req_ready, 1);

        // Reset during WAIT drops the access but keeps an already-accepted write
        issue3(1'b1, 32'hC, 32'h00000077);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_rst_valid", bus3.rsp_valid, 0);
        check("t6_rst_ready", bus3.req_ready, 1);
        issue3(1'b0, 32'hC, 32'h0);
        step();
        step();
        check("t6_rst_wr_kept", bus3.rsp_rdata, 32'h00000077);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
